// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: round-robin packet arbiter merging N valid/ready streams onto one skid-buffered output
module rr_stream_arbiter #(
  parameter int DW = 16,
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*DW-1:0] up_data,
  input  logic [N-1:0]    up_valid,
  input  logic [N-1:0]    up_last,
  output logic [N-1:0]    up_ready,
  output logic [DW-1:0]   down_data,
  output logic            down_last,
  output logic [SW-1:0]   down_src,
  output logic            down_valid,
  input  logic            down_ready
);
  typedef enum logic [1:0] {IDLE = 2'b01, GRANT = 2'b10} state_t;
  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_ptr, w_ptr_nxt, r_grant, w_grant_nxt, w_pick, w_off, w_gnext;
  logic [SW:0]   w_sum;
  logic [2*N-1:0] w_dbl;
  logic [N-1:0]  r_up_ready, w_up_ready_nxt;
  logic [DW-1:0] r_m_data, r_s_data, w_up_d;
  logic [SW-1:0] r_m_src, r_s_src;
  logic          r_m_last, r_s_last, r_m_valid, r_s_valid;
  logic          w_up_l, w_acc, w_main_free, w_m_ld, w_s_ld, w_m_valid_nxt, w_s_valid_nxt;

  // rotate so bit 0 is the requester at ptr; lowest set bit is the round-robin winner
  assign w_dbl = {up_valid, up_valid} >> r_ptr;
  always_comb begin
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) if (w_dbl[k]) w_off = SW'(k);
  end
  assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_pick = (w_sum >= (SW+1)'(N)) ? SW'(w_sum - (SW+1)'(N)) : w_sum[SW-1:0];
  assign w_gnext = (r_grant == SW'(N - 1)) ? '0 : r_grant + SW'(1);

  assign w_up_d = up_data[r_grant*DW +: DW];
  assign w_up_l = up_last[r_grant];
  assign w_acc  = |(up_valid & r_up_ready);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    if (r_state == IDLE) begin
      if (|up_valid) begin
        w_state_nxt = GRANT;
        w_grant_nxt = w_pick;
      end
    end else if (w_acc && w_up_l) begin
      w_state_nxt = IDLE;
      w_ptr_nxt   = w_gnext;
    end
  end

  // skid can only be full while up_ready is low, so it never collides with an acceptance
  assign w_main_free   = !r_m_valid || down_ready;
  assign w_m_ld        = w_main_free && (r_s_valid || w_acc);
  assign w_s_ld        = !w_main_free && w_acc;
  assign w_m_valid_nxt = w_main_free ? (r_s_valid || w_acc) : r_m_valid;
  assign w_s_valid_nxt = w_main_free ? 1'b0 : (r_s_valid || w_acc);
  assign w_up_ready_nxt = (w_state_nxt == GRANT && !w_s_valid_nxt) ? N'(1) << w_grant_nxt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_up_ready <= '0;
      r_m_valid  <= 1'b0;
      r_s_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_s_last   <= 1'b0;
      r_m_src    <= '0;
      r_s_src    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant    <= w_grant_nxt;
      r_up_ready <= w_up_ready_nxt;
      r_m_valid  <= w_m_valid_nxt;
      r_s_valid  <= w_s_valid_nxt;
      if (w_m_ld) begin
        r_m_last <= r_s_valid ? r_s_last : w_up_l;
        r_m_src  <= r_s_valid ? r_s_src : r_grant;
      end
      if (w_s_ld) begin
        r_s_last <= w_up_l;
        r_s_src  <= r_grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_m_ld) r_m_data <= r_s_valid ? r_s_data : w_up_d;
    if (w_s_ld) r_s_data <= w_up_d;
  end

  assign up_ready   = r_up_ready;
  assign down_data  = r_m_data;
  assign down_last  = r_m_last;
  assign down_src   = r_m_src;
  assign down_valid = r_m_valid;
endmodule
